dds_coef_arbiter: RTL and testbench
===================================

DDS_COEF_ARBITER -- requirements
Module: dds_coef_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each polynomial coefficient word.
REQ-002 Parameter ADDR_WIDTH, default 5, coefficient ROM segment address width (32 segments).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid[1:0]  input  2  per-channel fetch request (bit 0 = cos channel, bit 1 = sin channel).
REQ-006 req_addr0, req_addr1  input  ADDR_WIDTH each  segment address for channel 0 / channel 1.
REQ-007 req_ready[1:0]  output  2  per-channel accept strobe; at most one bit high per cycle.
REQ-008 rom_en  output  1  shared enable to the A0/A1/A2 coefficient ROMs.
REQ-009 rom_addr  output  ADDR_WIDTH  shared address to all three ROMs.
REQ-010 rom_a0, rom_a1, rom_a2  input  DATA_WIDTH each  ROM read data; registered in ROM, valid one cycle after the enabled edge.
REQ-011 resp_valid  output  1  coefficient set available.
REQ-012 resp_ready  input  1  consumer accepts coefficient set.
REQ-013 resp_ch  output  1  channel that owns the response.
REQ-014 resp_a0, resp_a1, resp_a2  output  DATA_WIDTH each  captured coefficients.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, RESP.
REQ-017 In IDLE with any req_valid set, arbiter SHALL assert req_ready for exactly one granted channel combinationally, latch that channel's address into rom_addr and the channel id, and move to FETCH.
REQ-018 If one channel requests, it SHALL be granted; if both request, the channel not granted last SHALL win; after reset channel 0 SHALL have priority.
REQ-019 req_ready SHALL be low in every state except IDLE; requests arriving outside IDLE SHALL wait (requesters hold req_valid and req_addr until accepted).
REQ-020 In FETCH rom_en SHALL be 1 for exactly one cycle; rom_en SHALL be 0 in all other states.
REQ-021 rom_addr SHALL hold its latched value from FETCH through RESP.
REQ-022 WAIT SHALL last one cycle; at its end rom_a0/a1/a2 SHALL be registered into resp_a0/a1/a2 and state SHALL go to RESP.
REQ-023 In RESP resp_valid SHALL be 1 and resp_* SHALL be stable until resp_valid && resp_ready; on that edge state SHALL return to IDLE.
REQ-024 Latency: accept edge N -> resp_valid high in cycle after edge N+2; minimum request period 4 cycles with resp_ready held high.
REQ-025 Simultaneous new req_valid during the RESP handshake cycle SHALL NOT be accepted until IDLE.
REQ-026 Round-robin pointer SHALL update only on a grant, not on resp handshake.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, req_ready 0, rom_en 0, rom_addr 0, resp_valid 0, resp_ch 0, resp_a0/a1/a2 0, busy 0, pointer favouring channel 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction without emitting resp_valid; after release the first request is handled normally.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, channel-id constants (CH_COS=0, CH_SIN=1) and default DATA_WIDTH/ADDR_WIDTH.
REQ-030 One sub-module dds_rr_arb2 (2-way round-robin grant with pointer) SHALL be used; FSM and capture registers stay in dds_coef_arbiter.

Verification
REQ-031 Single request: req_valid=01, req_addr0=5 -> req_ready=01 one cycle, rom_en one cycle with rom_addr=5, resp_valid with resp_ch=0 and resp_a0 = ROM word 5 (0x024b18fb in cos A0 table).
REQ-032 Contention: req_valid=11 from reset, addr0=0, addr1=31 -> ch0 served first (resp_a0=0x02000091), then ch1 (resp_a0=0xdabf1269); alternation over 4 consecutive grants 0,1,0,1.
REQ-033 Backpressure: resp_ready held 0 for 10 cycles -> resp_valid and resp_a* stable, req_ready stays 00, rom_en stays 0.
REQ-034 Reset in WAIT: rst_n pulsed low -> all outputs zero immediately, no resp_valid afterwards; next request completes correctly.
REQ-035 Throughput: continuous ch1 requests with resp_ready=1 -> one req_ready pulse every 4 cycles, addresses 0..31 wrap to 0 with correct data.

Source files
------------

// File: rtl/dds_coef_arbiter_pkg.sv
// Shared types and constants for the DDS coefficient fetch arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dds_coef_arbiter_pkg;

    // Default coefficient word width and ROM segment address width.
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    // Channel identifiers as carried on resp_ch and used for arbitration.
    localparam logic CH_COS = 1'b0;
    localparam logic CH_SIN = 1'b1;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Map a one-hot two-channel grant onto the winning channel id.
    function automatic logic grant_ch(input logic [1:0] grant);
        return grant[1] ? CH_SIN : CH_COS;
    endfunction

endpackage

// File: rtl/dds_rr_arb2.sv
// Two-way round-robin grant: one-hot grant among two requesters, ties go to the favoured channel.
// Latency: grant is combinational from req/en; favoured channel updates on the edge of a grant.
// Backpressure: when en is low nothing is granted and the favoured channel is held.
module dds_rr_arb2
    import dds_coef_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Channel that wins when both request; flips away from whoever was just served.
    logic favour;

    // Grant selection: a lone requester always wins, a tie goes to the favoured channel.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (favour == CH_SIN) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer moves only when a grant is actually issued, favouring the other channel next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour <= CH_COS;
        end else if (grant != 2'b00) begin
            favour <= ~grant_ch(grant);
        end
    end

endmodule

// File: rtl/dds_coef_arbiter.sv
// Arbitrates cos/sin coefficient fetches onto one shared A0/A1/A2 ROM set and returns the captured set.
// Latency: accept edge N -> rom_en during cycle after N -> resp_valid in cycle after edge N+2 (4-cycle min period).
// Backpressure: resp_valid holds with stable data until resp_ready; no new request is accepted until back in IDLE.
module dds_coef_arbiter
    import dds_coef_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    output logic [1:0]            req_ready,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_a0,
    input  logic [DATA_WIDTH-1:0] rom_a1,
    input  logic [DATA_WIDTH-1:0] rom_a2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_ch,
    output logic [DATA_WIDTH-1:0] resp_a0,
    output logic [DATA_WIDTH-1:0] resp_a1,
    output logic [DATA_WIDTH-1:0] resp_a2,
    output logic                  busy
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant;
    logic       arb_en;
    logic       accept;
    logic       ch_q;

    // Grants are only offered from IDLE; gating with rst_n keeps req_ready low while reset is held.
    assign arb_en = (state == ST_IDLE) && rst_n;
    assign accept = (grant != 2'b00);

    dds_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req_valid),
        .grant (grant)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs: one ROM enable cycle, one ROM wait cycle, then hold response.
    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        rom_en     = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                if (accept) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_en    = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the granted channel's address and id on accept; the address then stays put until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            ch_q     <= CH_COS;
        end else if (accept) begin
            rom_addr <= (grant_ch(grant) == CH_SIN) ? req_addr1 : req_addr0;
            ch_q     <= grant_ch(grant);
        end
    end

    // Capture ROM read data and owning channel together at the end of WAIT so resp_* switch as one set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_ch <= CH_COS;
            resp_a0 <= '0;
            resp_a1 <= '0;
            resp_a2 <= '0;
        end else if (state == ST_WAIT) begin
            resp_ch <= ch_q;
            resp_a0 <= rom_a0;
            resp_a1 <= rom_a1;
            resp_a2 <= rom_a2;
        end
    end

endmodule

// File: tb/tb_dds_coef_arbiter.sv
// Self-checking bench for dds_coef_arbiter: directed scenarios plus random traffic against a transaction model.
// Latency: n/a (testbench).
// Backpressure: resp_ready is driven both held-low and randomly.
module tb_dds_coef_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [1:0]    req_ready;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_a0 = '0;
    logic [DW-1:0] rom_a1 = '0;
    logic [DW-1:0] rom_a2 = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_ch;
    logic [DW-1:0] resp_a0;
    logic [DW-1:0] resp_a1;
    logic [DW-1:0] resp_a2;
    logic          busy;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    dds_coef_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_ready  (req_ready),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_a0     (rom_a0),
        .rom_a1     (rom_a1),
        .rom_a2     (rom_a2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_ch    (resp_ch),
        .resp_a0    (resp_a0),
        .resp_a1    (resp_a1),
        .resp_a2    (resp_a2),
        .busy       (busy)
    );

    // Coefficient table contents: a few known cos A0 words, the rest a fixed hash of (table, address).
    function automatic logic [31:0] rom_word(input int k, input logic [4:0] a);
        if (k == 0 && a == 5'd0)  return 32'h02000091;
        if (k == 0 && a == 5'd5)  return 32'h024b18fb;
        if (k == 0 && a == 5'd31) return 32'hdabf1269;
        return (32'h9e3779b9 * (32'(a) * 32'd3 + 32'(k) + 32'd1)) ^ (32'(k) << 28);
    endfunction

    // Registered ROMs: data appears one cycle after an enabled edge.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_a0 <= rom_word(0, rom_addr);
            rom_a1 <= rom_word(1, rom_addr);
            rom_a2 <= rom_word(2, rom_addr);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Which channel should be granted given requests and the channel favoured on a tie.
    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic favour_sin);
        if (v == 2'b11) return favour_sin ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Transaction model: age = cycles since accept (-1 when idle); 1 = ROM read, 2 = wait, 3 = response held.
    int          m_age = -1;
    logic        m_favour = 1'b0;
    logic        m_ch = 1'b0;
    logic [4:0]  m_addr = '0;
    logic        m_rch = 1'b0;
    logic [31:0] m_ra0 = '0;
    logic [31:0] m_ra1 = '0;
    logic [31:0] m_ra2 = '0;
    logic [1:0]  m_g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = -1; m_favour = 1'b0; m_ch = 1'b0; m_addr = '0;
            m_rch = 1'b0; m_ra0 = '0; m_ra1 = '0; m_ra2 = '0;
        end else if (m_age < 0) begin
            m_g = exp_grant(req_valid, m_favour);
            if (m_g != 2'b00) begin
                m_ch     = m_g[1];
                m_addr   = m_g[1] ? req_addr1 : req_addr0;
                m_favour = ~m_g[1];
                m_age    = 1;
            end
        end else if (m_age < 3) begin
            m_age = m_age + 1;
            if (m_age == 3) begin
                m_rch = m_ch;
                m_ra0 = rom_word(0, m_addr);
                m_ra1 = rom_word(1, m_addr);
                m_ra2 = rom_word(2, m_addr);
            end
        end else if (resp_ready) begin
            m_age = -1;
        end
    end

    // Every cycle, compare all DUT outputs against the model.
    always @(negedge clk) begin
        chk("req_ready", 64'(req_ready),
            64'((rst_n && m_age < 0) ? exp_grant(req_valid, m_favour) : 2'b00));
        chk("rom_en", 64'(rom_en), 64'(rst_n && m_age == 1));
        chk("rom_addr", 64'(rom_addr), 64'(m_addr));
        chk("resp_valid", 64'(resp_valid), 64'(rst_n && m_age == 3));
        chk("busy", 64'(busy), 64'(rst_n && m_age >= 0));
        chk("resp_ch", 64'(resp_ch), 64'(m_rch));
        chk("resp_a0", 64'(resp_a0), 64'(m_ra0));
        chk("resp_a1", 64'(resp_a1), 64'(m_ra1));
        chk("resp_a2", 64'(resp_a2), 64'(m_ra2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        chk(nm, 64'(busy), 64'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          grants[$];
        logic [31:0] datas[$];
        int          gcyc[$];
        logic [1:0]  rr;

        do_reset();

        // Single cos request at address 5.
        resp_ready = 1'b1; req_addr0 = 5'd5; req_valid = 2'b01;
        @(negedge clk); chk("t1_ready", 64'(req_ready), 64'(2'b01));
        step(); req_valid = 2'b00;
        @(negedge clk); chk("t1_rom_en", 64'(rom_en), 64'(1));
        chk("t1_rom_addr", 64'(rom_addr), 64'(5));
        @(negedge clk); chk("t1_wait_valid", 64'(resp_valid), 64'(0));
        @(negedge clk); chk("t1_valid", 64'(resp_valid), 64'(1));
        chk("t1_ch", 64'(resp_ch), 64'(0));
        chk("t1_a0", 64'(resp_a0), 64'(32'h024b18fb));
        step();
        @(negedge clk); chk("t1_idle", 64'(busy), 64'(0));

        // Contention from reset: both channels hold requests, grants must alternate 0,1,0,1.
        do_reset();
        resp_ready = 1'b1; req_addr0 = 5'd0; req_addr1 = 5'd31; req_valid = 2'b11;
        for (int i = 0; i < 60 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (req_ready == 2'b01) grants.push_back(0);
            else if (req_ready == 2'b10) grants.push_back(1);
            if (resp_valid && resp_ready) datas.push_back(resp_a0);
        end
        step(); req_valid = 2'b00;
        chk("t2_ngrants", 64'(grants.size()), 64'(4));
        for (int i = 0; i < grants.size(); i++) chk("t2_order", 64'(grants[i]), 64'(i % 2));
        chk("t2_nresp", 64'(datas.size() >= 2), 64'(1));
        chk("t2_first_a0", 64'(datas.size() > 0 ? datas[0] : 32'h0), 64'(32'h02000091));
        chk("t2_second_a0", 64'(datas.size() > 1 ? datas[1] : 32'h0), 64'(32'hdabf1269));
        wait_idle("t2_drain");

        // Backpressure: response held 10 cycles while both channels wait.
        resp_ready = 1'b0; req_addr0 = 5'd7; req_valid = 2'b01;
        @(negedge clk); chk("t3_ready", 64'(req_ready), 64'(2'b01));
        step(); req_valid = 2'b11; req_addr1 = 5'd3;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_valid", 64'(resp_valid), 64'(1));
            chk("t3_a0", 64'(resp_a0), 64'(rom_word(0, 5'd7)));
            chk("t3_a2", 64'(resp_a2), 64'(rom_word(2, 5'd7)));
            chk("t3_no_ready", 64'(req_ready), 64'(0));
            chk("t3_no_rom_en", 64'(rom_en), 64'(0));
        end
        #1 resp_ready = 1'b1;
        #1 chk("t3_hs_ready", 64'(req_ready), 64'(0));
        @(negedge clk); chk("t3_next_grant", 64'(req_ready), 64'(2'b10));
        step(); req_valid = 2'b00;
        wait_idle("t3_drain");

        // Reset while waiting on ROM data: abandon the fetch, then a fresh request completes.
        req_addr1 = 5'd9; req_valid = 2'b10;
        @(negedge clk); chk("t4_ready", 64'(req_ready), 64'(2'b10));
        step(); req_valid = 2'b00;
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 64'(busy), 64'(0));
        chk("t4_rst_rom_addr", 64'(rom_addr), 64'(0));
        chk("t4_rst_a0", 64'(resp_a0), 64'(0));
        chk("t4_rst_valid", 64'(resp_valid), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("t4_no_resp", 64'(resp_valid), 64'(0));
        end
        step(); req_valid = 2'b10;
        @(negedge clk); chk("t4_re_ready", 64'(req_ready), 64'(2'b10));
        step(); req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("t4_re_valid", 64'(resp_valid), 64'(1));
        chk("t4_re_ch", 64'(resp_ch), 64'(1));
        chk("t4_re_a0", 64'(resp_a0), 64'(rom_word(0, 5'd9)));
        step();
        wait_idle("t4_drain");

        // Throughput: continuous sin requests sweeping addresses with wrap.
        req_addr1 = 5'd0; req_valid = 2'b10; resp_ready = 1'b1;
        for (int i = 0; i < 400 && gcyc.size() < 34; i++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                gcyc.push_back(cyc_n);
                step();
                req_addr1 = req_addr1 + 5'd1;
            end
        end
        req_valid = 2'b00;
        chk("t5_ngrants", 64'(gcyc.size()), 64'(34));
        for (int k = 1; k < gcyc.size(); k++) chk("t5_period", 64'(gcyc[k] - gcyc[k-1]), 64'(4));
        wait_idle("t5_drain");

        // Random traffic; requesters hold until accepted, occasional backpressure and one reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rr = req_ready;
            step();
            if (i == 700) begin
                do_reset();
            end
            if (req_valid[0] ? rr[0] : 1'b1) begin
                req_valid[0] = req_valid[0] ? 1'($urandom % 2) : ($urandom % 3 == 0);
                req_addr0 = 5'($urandom);
            end
            if (req_valid[1] ? rr[1] : 1'b1) begin
                req_valid[1] = req_valid[1] ? 1'($urandom % 2) : ($urandom % 3 == 0);
                req_addr1 = 5'($urandom);
            end
            resp_ready = ($urandom % 4 != 0);
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        wait_idle("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
